// File: rtl/iterative_divider_if.sv
// Request/result bundle for the iterative divider: the master issues start with
// operands, and the slave returns busy/done and the held results.
interface iterative_divider_if #(
    parameter int dividend_width = 16,
    parameter int divisor_width  = 8
);
    logic                      start;
    logic [dividend_width-1:0] dividend;
    logic [divisor_width-1:0]  divisor;
    logic                      busy;
    logic                      done;
    logic [dividend_width-1:0] quotient;
    logic [divisor_width-1:0]  remainder;
    logic                      div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/iterative_divider.sv
// Restoring unsigned divider producing one quotient bit per clock. A zero
// divisor completes immediately with an all-ones quotient and a flag.
module iterative_divider #(
    parameter int dividend_width = 16,
    parameter int divisor_width  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    iterative_divider_if.slave div_if
);
    localparam int DW = dividend_width;
    localparam int VW = divisor_width;
    localparam int CW = $clog2(DW + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          r_state, w_next_state;
    logic [DW-1:0]   r_dvd;
    logic [VW-1:0]   r_dvs;
    logic [VW:0]     r_prem;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_quot;
    logic [VW-1:0]   r_rem;
    logic            r_dbz;
    logic            r_done;

    logic            w_accept, w_zero, w_finish;
    logic [VW+1:0]   w_shift;
    logic [VW:0]     w_diff;
    logic            w_qbit;
    logic [VW:0]     w_prem_nxt;
    logic [DW-1:0]   w_quot_nxt;

    // r_dvd shifts the dividend out at the top while quotient bits enter at the bottom.
    assign w_shift    = {r_prem, r_dvd[DW-1]};
    assign w_qbit     = (w_shift >= {2'b00, r_dvs});
    assign w_diff     = w_shift[VW:0] - {1'b0, r_dvs};
    assign w_prem_nxt = w_qbit ? w_diff : w_shift[VW:0];
    assign w_quot_nxt = {r_dvd[DW-2:0], w_qbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_zero       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (div_if.start) begin
                    if (div_if.divisor == '0) begin
                        w_zero = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        w_next_state = RUN;
                    end
                end
            end
            RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_finish     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_prem <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish | w_zero;
            if (w_accept) begin
                r_dvd  <= div_if.dividend;
                r_dvs  <= div_if.divisor;
                r_prem <= '0;
                r_cnt  <= CW'(DW);
            end else if (r_state == RUN) begin
                r_dvd  <= w_quot_nxt;
                r_prem <= w_prem_nxt;
                r_cnt  <= r_cnt - CW'(1);
            end
            if (w_finish) begin
                r_quot <= w_quot_nxt;
                r_rem  <= w_prem_nxt[VW-1:0];
                r_dbz  <= 1'b0;
            end else if (w_zero) begin
                r_quot <= '1;
                r_rem  <= '0;
                r_dbz  <= 1'b1;
            end
        end
    end

    assign div_if.busy        = (r_state == RUN);
    assign div_if.done        = r_done;
    assign div_if.quotient    = r_quot;
    assign div_if.remainder   = r_rem;
    assign div_if.div_by_zero = r_dbz;
endmodule

// File: tb/tb_iterative_divider.sv
// Directed bench for iterative_divider: each task drives one scenario and
// compares the results against hand-computed quotients and remainders.
module tb_iterative_divider;
    localparam int DW = 16;
    localparam int VW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    iterative_divider_if #(.dividend_width(DW), .divisor_width(VW)) dif();

    iterative_divider #(.dividend_width(DW), .divisor_width(VW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_if (dif)
    );

    // Drives start for exactly one rising edge; returns at the negedge after acceptance.
    task automatic do_start(input logic [DW-1:0] a, input logic [VW-1:0] b);
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = a; dif.divisor = b;
        @(negedge clk);
        dif.start = 1'b0; dif.dividend = 16'hA5A5; dif.divisor = 8'h3C;
    endtask

    // Bounded wait for done; lat counts negedges, bcnt counts busy-high samples.
    task automatic wait_done(output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        while (dif.done !== 1'b1 && lat < 40) begin
            if (dif.busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dif.start = 1'b0; dif.dividend = '0; dif.divisor = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (dif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", dif.busy); end
        n_checks++; if (dif.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", dif.done); end
        n_checks++; if (dif.quotient !== 16'd0) begin n_fail++; $display("FAIL reset_q: got %0d want 0", dif.quotient); end
        n_checks++; if (dif.remainder !== 8'd0) begin n_fail++; $display("FAIL reset_r: got %0d want 0", dif.remainder); end
        n_checks++; if (dif.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", dif.div_by_zero); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bcnt;
        do_start(16'd100, 8'd7);
        n_checks++; if (dif.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_start: got %b want 1", dif.busy); end
        wait_done(lat, bcnt);
        n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL basic_latency: got %0d want 16", lat); end
        n_checks++; if (bcnt !== 16) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 16", bcnt); end
        n_checks++; if (dif.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done: got %b want 0", dif.busy); end
        n_checks++; if (dif.quotient !== 16'd14) begin n_fail++; $display("FAIL basic_q: got %0d want 14", dif.quotient); end
        n_checks++; if (dif.remainder !== 8'd2) begin n_fail++; $display("FAIL basic_r: got %0d want 2", dif.remainder); end
        n_checks++; if (dif.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz: got %b want 0", dif.div_by_zero); end
        @(negedge clk);
        n_checks++; if (dif.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", dif.done); end
    endtask

    task automatic test_extremes();
        int lat, bcnt;
        do_start(16'hFFFF, 8'd1);
        wait_done(lat, bcnt);
        n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL max_latency: got %0d want 16", lat); end
        n_checks++; if (dif.quotient !== 16'hFFFF) begin n_fail++; $display("FAIL max_q: got %h want ffff", dif.quotient); end
        n_checks++; if (dif.remainder !== 8'd0) begin n_fail++; $display("FAIL max_r: got %0d want 0", dif.remainder); end
        do_start(16'd200, 8'd255);
        wait_done(lat, bcnt);
        n_checks++; if (dif.quotient !== 16'd0) begin n_fail++; $display("FAIL small_q: got %0d want 0", dif.quotient); end
        n_checks++; if (dif.remainder !== 8'd200) begin n_fail++; $display("FAIL small_r: got %0d want 200", dif.remainder); end
    endtask

    task automatic test_div_by_zero();
        int lat, bcnt;
        do_start(16'd5, 8'd0);
        n_checks++; if (dif.done !== 1'b1) begin n_fail++; $display("FAIL dbz_done: got %b want 1", dif.done); end
        n_checks++; if (dif.busy !== 1'b0) begin n_fail++; $display("FAIL dbz_busy: got %b want 0", dif.busy); end
        n_checks++; if (dif.quotient !== 16'hFFFF) begin n_fail++; $display("FAIL dbz_q: got %h want ffff", dif.quotient); end
        n_checks++; if (dif.remainder !== 8'd0) begin n_fail++; $display("FAIL dbz_r: got %0d want 0", dif.remainder); end
        n_checks++; if (dif.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b want 1", dif.div_by_zero); end
        @(negedge clk);
        n_checks++; if (dif.done !== 1'b0) begin n_fail++; $display("FAIL dbz_done_clear: got %b want 0", dif.done); end
        n_checks++; if (dif.busy !== 1'b0) begin n_fail++; $display("FAIL dbz_busy_after: got %b want 0", dif.busy); end
        do_start(16'd100, 8'd7);
        n_checks++; if (dif.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_held: got %b want 1", dif.div_by_zero); end
        n_checks++; if (dif.quotient !== 16'hFFFF) begin n_fail++; $display("FAIL dbz_q_held: got %h want ffff", dif.quotient); end
        wait_done(lat, bcnt);
        n_checks++; if (dif.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_cleared: got %b want 0", dif.div_by_zero); end
        n_checks++; if (dif.quotient !== 16'd14) begin n_fail++; $display("FAIL dbz_next_q: got %0d want 14", dif.quotient); end
    endtask

    task automatic test_ignore_busy();
        int lat, bcnt, extra;
        do_start(16'd1000, 8'd9);
        repeat (4) @(negedge clk);
        dif.start = 1'b1; dif.dividend = 16'd7; dif.divisor = 8'd7;
        @(negedge clk);
        dif.start = 1'b0;
        wait_done(lat, bcnt);
        n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL ignore_latency: got %0d want 11", lat); end
        n_checks++; if (dif.quotient !== 16'd111) begin n_fail++; $display("FAIL ignore_q: got %0d want 111", dif.quotient); end
        n_checks++; if (dif.remainder !== 8'd1) begin n_fail++; $display("FAIL ignore_r: got %0d want 1", dif.remainder); end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (dif.done !== 1'b0 || dif.busy !== 1'b0) extra++;
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ignore_single_done: got %0d extra active cycles want 0", extra); end
    endtask

    task automatic test_reset_abort();
        int lat, bcnt, extra;
        do_start(16'd1000, 8'd9);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (dif.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", dif.busy); end
        n_checks++; if (dif.done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", dif.done); end
        n_checks++; if (dif.quotient !== 16'd0) begin n_fail++; $display("FAIL abort_q: got %0d want 0", dif.quotient); end
        n_checks++; if (dif.remainder !== 8'd0) begin n_fail++; $display("FAIL abort_r: got %0d want 0", dif.remainder); end
        n_checks++; if (dif.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL abort_dbz: got %b want 0", dif.div_by_zero); end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (24) begin
            @(negedge clk);
            if (dif.done !== 1'b0 || dif.busy !== 1'b0) extra++;
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles want 0", extra); end
        do_start(16'd50, 8'd5);
        wait_done(lat, bcnt);
        n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL abort_next_latency: got %0d want 16", lat); end
        n_checks++; if (dif.quotient !== 16'd10) begin n_fail++; $display("FAIL abort_next_q: got %0d want 10", dif.quotient); end
        n_checks++; if (dif.remainder !== 8'd0) begin n_fail++; $display("FAIL abort_next_r: got %0d want 0", dif.remainder); end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        do_start(16'd300, 8'd17);
        wait_done(lat, bcnt);
        n_checks++; if (dif.quotient !== 16'd17) begin n_fail++; $display("FAIL b2b_first_q: got %0d want 17", dif.quotient); end
        n_checks++; if (dif.remainder !== 8'd11) begin n_fail++; $display("FAIL b2b_first_r: got %0d want 11", dif.remainder); end
        dif.start = 1'b1; dif.dividend = 16'd81; dif.divisor = 8'd9;
        @(negedge clk);
        dif.start = 1'b0;
        n_checks++; if (dif.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b want 1", dif.busy); end
        n_checks++; if (dif.done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_clear: got %b want 0", dif.done); end
        n_checks++; if (dif.quotient !== 16'd17) begin n_fail++; $display("FAIL b2b_q_held: got %0d want 17", dif.quotient); end
        wait_done(lat, bcnt);
        n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL b2b_latency: got %0d want 16", lat); end
        n_checks++; if (dif.quotient !== 16'd9) begin n_fail++; $display("FAIL b2b_second_q: got %0d want 9", dif.quotient); end
        n_checks++; if (dif.remainder !== 8'd0) begin n_fail++; $display("FAIL b2b_second_r: got %0d want 0", dif.remainder); end
        @(negedge clk);
        n_checks++; if (dif.done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_pulse: got %b want 0", dif.done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_by_zero();
        test_ignore_busy();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end
endmodule
